// File: rtl/mux_rr_arbiter.sv
// Round-robin packet arbiter: picks one upstream requester, locks the mux
// select for the whole packet (through s_last), then rotates priority.
module mux_rr_arbiter #(
    parameter int SEL_BITS  = 2,
    parameter int N         = 1 << SEL_BITS,
    parameter int DATA_BITS = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   cke,
    input  logic [N-1:0]           s_valid,
    input  logic [N-1:0]           s_last,
    input  logic [N*DATA_BITS-1:0] s_data,
    output logic [N-1:0]           s_ready,
    output logic                   m_valid,
    output logic                   m_last,
    output logic [DATA_BITS-1:0]   m_data,
    input  logic                   m_ready,
    output logic [SEL_BITS-1:0]    m_sel,
    output logic                   busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam logic [SEL_BITS-1:0] SEL_ONE = SEL_BITS'(1);
    localparam logic [N-1:0]        REQ_ONE = N'(1);

    state_t              state_r;
    state_t              next_state_s;
    logic [SEL_BITS-1:0] sel_r;
    logic [SEL_BITS-1:0] next_sel_s;
    logic [SEL_BITS-1:0] ptr_r;
    logic [SEL_BITS-1:0] next_ptr_s;
    logic                lock_s;
    logic                xfer_s;

    // First requesting index at or after start; index arithmetic wraps since N is a power of two.
    function automatic logic [SEL_BITS-1:0] rr_pick(
        input logic [N-1:0]        req,
        input logic [SEL_BITS-1:0] start
    );
        logic [SEL_BITS-1:0] pick;
        logic [SEL_BITS-1:0] idx;
        logic                found;
        pick  = start;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = start + k[SEL_BITS-1:0];
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Datapath and handshake outputs follow the locked select.
    always_comb begin
        lock_s  = (state_r == LOCK);
        m_valid = cke & lock_s & s_valid[sel_r];
        m_last  = s_last[sel_r];
        m_data  = s_data[sel_r*DATA_BITS +: DATA_BITS];
        busy    = lock_s;
        m_sel   = sel_r;
        xfer_s  = m_valid & m_ready;
        if (cke && lock_s && m_ready) begin
            s_ready = REQ_ONE << sel_r;
        end else begin
            s_ready = {N{1'b0}};
        end
    end

    // Arbitration in IDLE; release and priority rotation after the last beat.
    always_comb begin
        next_state_s = state_r;
        next_sel_s   = sel_r;
        next_ptr_s   = ptr_r;
        case (state_r)
            IDLE: begin
                if (|s_valid) begin
                    next_sel_s   = rr_pick(s_valid, ptr_r);
                    next_state_s = LOCK;
                end else begin
                    next_state_s = IDLE;
                end
            end
            LOCK: begin
                // Gaps inside a packet keep the lock; only a last transfer releases it.
                if (xfer_s && s_last[sel_r]) begin
                    next_state_s = IDLE;
                    next_ptr_s   = sel_r + SEL_ONE;
                end else begin
                    next_state_s = LOCK;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // State registers; everything holds while cke is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            sel_r   <= {SEL_BITS{1'b0}};
            ptr_r   <= {SEL_BITS{1'b0}};
        end else if (cke) begin
            state_r <= next_state_s;
            sel_r   <= next_sel_s;
            ptr_r   <= next_ptr_s;
        end else begin
            state_r <= state_r;
            sel_r   <= sel_r;
            ptr_r   <= ptr_r;
        end
    end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: vector table for rotation plus
// hand sequences for multi-beat, gap, clock-enable and async reset cases.
module tb_mux_rr_arbiter;

    logic        clk;
    logic        reset;
    logic        cke;
    logic [3:0]  s_valid;
    logic [3:0]  s_last;
    logic [31:0] s_data;
    logic [3:0]  s_ready;
    logic        m_valid;
    logic        m_last;
    logic [7:0]  m_data;
    logic        m_ready;
    logic [1:0]  m_sel;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] sel;
        logic [7:0] data;
        logic       last;
    } beat_t;

    typedef struct {
        logic       cke;
        logic [3:0] valid;
        logic [3:0] last;
        logic       ready;
        logic       exp_mv;
        logic [1:0] exp_sel;
        logic       exp_busy;
        logic [3:0] exp_sr;
    } vec_t;

    beat_t sb_q[$];
    vec_t  tbl[11];

    mux_rr_arbiter #(.SEL_BITS(2), .DATA_BITS(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .cke     (cke),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_data  (s_data),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_last  (m_last),
        .m_data  (m_data),
        .m_ready (m_ready),
        .m_sel   (m_sel),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic mv, input logic [1:0] sel,
                              input logic b, input logic [3:0] sr);
        check({tag, ".m_valid"}, {31'd0, m_valid}, {31'd0, mv});
        check({tag, ".m_sel"},   {30'd0, m_sel},   {30'd0, sel});
        check({tag, ".busy"},    {31'd0, busy},    {31'd0, b});
        check({tag, ".s_ready"}, {28'd0, s_ready}, {28'd0, sr});
    endtask

    task automatic step(input logic c, input logic [3:0] v, input logic [3:0] l,
                        input logic r, input logic [31:0] dat);
        @(negedge clk);
        cke     = c;
        s_valid = v;
        s_last  = l;
        m_ready = r;
        s_data  = dat;
        #1;
    endtask

    task automatic sb_push(input logic [1:0] sel, input logic [7:0] data, input logic last);
        beat_t b;
        b.sel  = sel;
        b.data = data;
        b.last = last;
        sb_q.push_back(b);
    endtask

    // Scoreboard: every delivered beat must match the next expected beat.
    always @(negedge clk) begin
        #2;
        if (m_valid && m_ready) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_beat actual sel=%0d data=%0h required none", m_sel, m_data);
            end else begin
                beat_t e;
                e = sb_q.pop_front();
                check("beat.sel",  {30'd0, m_sel},  {30'd0, e.sel});
                check("beat.data", {24'd0, m_data}, {24'd0, e.data});
                check("beat.last", {31'd0, m_last}, {31'd0, e.last});
            end
        end
    end

    initial begin
        logic [31:0] tbl_data;
        logic [31:0] d;
        reset   = 1'b1;
        cke     = 1'b1;
        s_valid = 4'h0;
        s_last  = 4'h0;
        m_ready = 1'b0;
        s_data  = 32'h0;

        @(negedge clk);
        #1;
        expect_out("reset", 1'b0, 2'd0, 1'b0, 4'h0);
        reset = 1'b0;

        // Single beat from requester 2, then ptr=3 shows up as priority to 3 over 0.
        d = 32'hD3C2B1A0;
        step(1'b1, 4'b0100, 4'b0100, 1'b1, d);
        expect_out("a.idle", 1'b0, 2'd0, 1'b0, 4'h0);
        step(1'b1, 4'b0100, 4'b0100, 1'b1, d);
        expect_out("a.grant2", 1'b1, 2'd2, 1'b1, 4'b0100);
        sb_push(2'd2, 8'hC2, 1'b1);
        step(1'b1, 4'b0000, 4'b0000, 1'b1, d);
        expect_out("a.bubble", 1'b0, 2'd2, 1'b0, 4'h0);
        step(1'b1, 4'b1001, 4'b1001, 1'b1, d);
        expect_out("a.idle2", 1'b0, 2'd2, 1'b0, 4'h0);
        step(1'b1, 4'b1001, 4'b1001, 1'b1, d);
        expect_out("a.grant3", 1'b1, 2'd3, 1'b1, 4'b1000);
        sb_push(2'd3, 8'hD3, 1'b1);

        // All four requesting single-beat packets: strictly cyclic grants with bubbles.
        tbl_data = 32'h44332211;
        tbl[0]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 2'd3, 1'b0, 4'b0000};
        tbl[1]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001};
        tbl[2]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
        tbl[3]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 2'd1, 1'b1, 4'b0010};
        tbl[4]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 2'd1, 1'b0, 4'b0000};
        tbl[5]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 2'd2, 1'b1, 4'b0100};
        tbl[6]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 2'd2, 1'b0, 4'b0000};
        tbl[7]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 2'd3, 1'b1, 4'b1000};
        tbl[8]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 2'd3, 1'b0, 4'b0000};
        tbl[9]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 2'd0, 1'b1, 4'b0001};
        tbl[10] = '{1'b1, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 4'b0000};
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].cke, tbl[i].valid, tbl[i].last, tbl[i].ready, tbl_data);
            expect_out($sformatf("tbl%0d", i), tbl[i].exp_mv, tbl[i].exp_sel,
                       tbl[i].exp_busy, tbl[i].exp_sr);
            if (tbl[i].exp_mv && tbl[i].ready) begin
                sb_push(tbl[i].exp_sel, tbl_data[tbl[i].exp_sel*8 +: 8], 1'b1);
            end
        end

        // Three-beat packet from requester 1 with requester 0 pending; m_ready 1,0,1,1.
        step(1'b1, 4'b0011, 4'b0000, 1'b1, 32'h0000A155);
        expect_out("c.idle", 1'b0, 2'd0, 1'b0, 4'h0);
        step(1'b1, 4'b0011, 4'b0000, 1'b1, 32'h0000A155);
        expect_out("c.b1", 1'b1, 2'd1, 1'b1, 4'b0010);
        sb_push(2'd1, 8'hA1, 1'b0);
        step(1'b1, 4'b0011, 4'b0000, 1'b0, 32'h0000A255);
        expect_out("c.stall", 1'b1, 2'd1, 1'b1, 4'b0000);
        step(1'b1, 4'b0011, 4'b0000, 1'b1, 32'h0000A255);
        expect_out("c.b2", 1'b1, 2'd1, 1'b1, 4'b0010);
        sb_push(2'd1, 8'hA2, 1'b0);
        step(1'b1, 4'b0011, 4'b0010, 1'b1, 32'h0000A355);
        expect_out("c.b3", 1'b1, 2'd1, 1'b1, 4'b0010);
        sb_push(2'd1, 8'hA3, 1'b1);
        step(1'b1, 4'b0001, 4'b0001, 1'b1, 32'h00000055);
        expect_out("c.bubble", 1'b0, 2'd1, 1'b0, 4'h0);
        step(1'b1, 4'b0001, 4'b0001, 1'b1, 32'h00000055);
        expect_out("c.grant0", 1'b1, 2'd0, 1'b1, 4'b0001);
        sb_push(2'd0, 8'h55, 1'b1);

        // Gap inside a packet on requester 3 while requester 0 waits.
        step(1'b1, 4'b1000, 4'b0000, 1'b1, 32'hD1000066);
        expect_out("d.idle", 1'b0, 2'd0, 1'b0, 4'h0);
        step(1'b1, 4'b1000, 4'b0000, 1'b1, 32'hD1000066);
        expect_out("d.b1", 1'b1, 2'd3, 1'b1, 4'b1000);
        sb_push(2'd3, 8'hD1, 1'b0);
        for (int g = 0; g < 2; g++) begin
            step(1'b1, 4'b0001, 4'b0000, 1'b1, 32'hD2000066);
            expect_out($sformatf("d.gap%0d", g), 1'b0, 2'd3, 1'b1, 4'b1000);
        end
        step(1'b1, 4'b1001, 4'b1000, 1'b1, 32'hD2000066);
        expect_out("d.b2", 1'b1, 2'd3, 1'b1, 4'b1000);
        sb_push(2'd3, 8'hD2, 1'b1);
        step(1'b1, 4'b0001, 4'b0001, 1'b1, 32'h00000066);
        expect_out("d.bubble", 1'b0, 2'd3, 1'b0, 4'h0);
        step(1'b1, 4'b0001, 4'b0001, 1'b1, 32'h00000066);
        expect_out("d.grant0", 1'b1, 2'd0, 1'b1, 4'b0001);
        sb_push(2'd0, 8'h66, 1'b1);

        // Clock enable low for three cycles mid-packet on requester 2.
        step(1'b1, 4'b0100, 4'b0000, 1'b1, 32'h00E10000);
        expect_out("e.idle", 1'b0, 2'd0, 1'b0, 4'h0);
        step(1'b1, 4'b0100, 4'b0000, 1'b1, 32'h00E10000);
        expect_out("e.b1", 1'b1, 2'd2, 1'b1, 4'b0100);
        sb_push(2'd2, 8'hE1, 1'b0);
        for (int h = 0; h < 3; h++) begin
            step(1'b0, 4'b0100, 4'b0100, 1'b1, 32'h00E20000);
            expect_out($sformatf("e.hold%0d", h), 1'b0, 2'd2, 1'b1, 4'b0000);
        end
        step(1'b1, 4'b0100, 4'b0100, 1'b1, 32'h00E20000);
        expect_out("e.b2", 1'b1, 2'd2, 1'b1, 4'b0100);
        sb_push(2'd2, 8'hE2, 1'b1);
        step(1'b1, 4'b0000, 4'b0000, 1'b1, 32'h0);
        expect_out("e.bubble", 1'b0, 2'd2, 1'b0, 4'h0);

        // Asynchronous reset mid-packet with sel=2, then search restarts from index 0.
        step(1'b1, 4'b0100, 4'b0000, 1'b0, 32'h00F20000);
        expect_out("f.idle", 1'b0, 2'd2, 1'b0, 4'h0);
        step(1'b1, 4'b0100, 4'b0000, 1'b0, 32'h00F20000);
        expect_out("f.lock", 1'b1, 2'd2, 1'b1, 4'b0000);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        expect_out("f.reset", 1'b0, 2'd0, 1'b0, 4'h0);
        reset = 1'b0;
        step(1'b1, 4'b0110, 4'b0110, 1'b1, 32'h00F2F100);
        expect_out("f.idle2", 1'b0, 2'd0, 1'b0, 4'h0);
        step(1'b1, 4'b0110, 4'b0110, 1'b1, 32'h00F2F100);
        expect_out("f.grant1", 1'b1, 2'd1, 1'b1, 4'b0010);
        sb_push(2'd1, 8'hF1, 1'b1);
        step(1'b1, 4'b0000, 4'b0000, 1'b1, 32'h0);
        expect_out("f.bubble", 1'b0, 2'd1, 1'b0, 4'h0);

        @(negedge clk);
        #3;
        check("sb.empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
Name: mux_rr_arbiter

Overview:
- Round-robin packet arbiter that shares one downstream stream port among N = 2^SEL_BITS upstream requesters.
- Internally it is a registered-select mux controller: it picks a requester, locks the mux select for a whole packet (up to s_last), then releases it.
- Used in the FPGA op-synthesis evaluation projects as the sequencing wrapper around the wide-mux datapath, so that mux resource use can be measured with real control logic attached.

Parameters:
- SEL_BITS, 2, width of the select and grant index.
- N, 1<<SEL_BITS, number of requesters (derived; not overridden).
- DATA_BITS, 8, payload width per requester.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous active-high reset.
- cke  input  1  clock enable; when 0, all state holds.
- s_valid  input  N  per-requester valid.
- s_last  input  N  per-requester end-of-packet flag.
- s_data  input  N*DATA_BITS  per-requester payload; requester i occupies bits [i*DATA_BITS +: DATA_BITS].
- s_ready  output  N  per-requester ready.
- m_valid  output  1  downstream valid.
- m_last  output  1  downstream end-of-packet.
- m_data  output  DATA_BITS  downstream payload.
- m_ready  input  1  downstream ready.
- m_sel  output  SEL_BITS  currently granted index (registered).
- busy  output  1  1 while in LOCK.

Behaviour:
- Registers: state {IDLE, LOCK}, sel[SEL_BITS], ptr[SEL_BITS].
- Reset (asynchronous, active-high): state=IDLE, sel=0, ptr=0. All outputs then read 0 (m_valid=0, s_ready=0, busy=0, m_sel=0, m_data=s_data[0] slice is permitted but must be ignored while m_valid=0).
- Reset asserted mid-packet aborts the packet with no flush. The next arbitration searches from index 0.
- Register updates occur only on edges where cke=1.
- Combinational outputs:
  - m_valid = cke & (state==LOCK) & s_valid[sel]
  - m_last = s_last[sel]
  - m_data = s_data slice sel
  - s_ready[i] = cke & (state==LOCK) & (sel==i) & m_ready
  - busy = (state==LOCK); m_sel = sel
- Transfer: a cycle with m_valid & m_ready (equivalently s_valid[sel] & s_ready[sel]).
- IDLE:
  - If any s_valid is set, choose the first index j with s_valid[j]=1, searching ptr, ptr+1, …, wrapping modulo N.
  - Next edge: sel<=j, state<=LOCK.
  - No valid: remain in IDLE.
  - No data moves in IDLE.
- LOCK:
  - Transfer with m_last=1: state<=IDLE, ptr<=sel+1 (wraps from N-1 to 0).
  - Transfer with m_last=0: stay in LOCK.
  - s_valid[sel]=0: stay in LOCK, never re-arbitrate mid-packet (gaps inside a packet are allowed).
- Latency: first beat is presented 1 cycle after the requester asserts valid in IDLE. One mandatory IDLE bubble cycle follows each packet's last transfer.
- Single-beat packet (valid & last together): occupies exactly 1 LOCK cycle when m_ready=1.
- Fairness: after requester k finishes, every other pending requester is served before k again. With N requesters all continuously requesting, the grant order is strictly cyclic.
- Requesters not granted see s_ready=0. Their valid/data must be held stable by them (stream rule). The arbiter never drops a beat.
- cke=0 in LOCK: m_valid=0 and s_ready=0, so no transfer occurs. State, sel and ptr hold.
- N=2 (SEL_BITS=1) and larger N must be supported by the same RTL. ptr and sel are never out of range.

Test Plan:
- Reset then s_valid=4'b0100, single beat, last=1, m_ready=1, cke=1 → m_sel=2 and m_valid=1 on the 2nd cycle. s_ready[2]=1 that cycle. Next cycle state=IDLE, ptr=3.
- s_valid=4'b1111 held continuously, each packet 1 beat, m_ready=1 → grant sequence 0,1,2,3,0,… Each grant is separated by one idle cycle.
- Requester 1 sends a 3-beat packet (0xA1,0xA2,0xA3; last on 3rd) while requester 0 is also valid. m_ready toggles 1,0,1,1 → all 3 beats are delivered in order and m_sel stays 1 throughout. Requester 0 is granted only afterwards.
- During LOCK with sel=3, drive s_valid[3]=0 for 2 cycles while s_valid[0]=1 → m_valid=0, busy=1, m_sel stays 3 (no re-arbitration).
- cke=0 for 3 cycles in mid-packet with m_ready=1 → no transfers, s_ready=0. The packet resumes intact when cke=1.
- Assert reset asynchronously (between clock edges) mid-packet with sel=2 → busy=0, m_sel=0, m_valid=0 immediately. After release with s_valid=4'b0110, requester 1 is granted (search restarts from 0).
